state_machine: RTL and testbench



---
 rtl/state_machine_if.sv | 32 +++
 rtl/state_machine.sv | 109 ++++++++++
 tb/tb_state_machine.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/state_machine_if.sv
// Controller/datapath bundle: hand scores and third card in, card-register loads and win lights out.
// Latency: n/a (wiring only).
// Backpressure: none. Loads are level enables sampled by the datapath on the slow clock.
interface state_machine_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;

  // Controller side
  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light
  );

  // Datapath side
  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light
  );
endinterface

// File: rtl/state_machine.sv
// Baccarat game-flow controller: deals PC1,DC1,PC2,DC2, applies third-card rules, then latches WIN.
// Latency: one state per slow_clock edge; loads are registered, win lights are combinational in WIN.
// Backpressure: none. The game advances on every edge and WIN holds until resetb.
module state_machine (
  input  logic       slow_clock,
  input  logic       resetb,
  state_machine_if.master bus
);

  typedef enum logic [2:0] {
    PC1 = 3'd0,
    DC1 = 3'd1,
    PC2 = 3'd2,
    DC2 = 3'd3,
    PC3 = 3'd4,
    DC3 = 3'd5,
    WIN = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] loads_q;   // {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}
  logic       win_q;

  // Baccarat value of the player's third card. Tens, faces and unused codes count 0.
  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  // Banker third-card rule, given the dealer score and the player third-card value
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] v);
    logic d;
    d = 1'b0;
    case (ds)
      4'd0, 4'd1, 4'd2: d = 1'b1;
      4'd3:             d = (v != 4'd8);
      4'd4:             d = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             d = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             d = (v >= 4'd6) && (v <= 4'd7);
      default:          d = 1'b0;
    endcase
    return d;
  endfunction

  // Moore load decode. Applied to the next state so the registered loads line up with state.
  function automatic logic [5:0] load_decode(input state_t s);
    logic [5:0] l;
    l = 6'b000000;
    case (s)
      PC1:     l = 6'b100000;
      PC2:     l = 6'b010000;
      PC3:     l = 6'b001000;
      DC1:     l = 6'b000100;
      DC2:     l = 6'b000010;
      DC3:     l = 6'b000001;
      default: l = 6'b000000;
    endcase
    return l;
  endfunction

  // Next-state decision. Scores and pcard3 are taken as seen on the edge leaving DC2/PC3.
  always_comb begin
    state_nxt = PC1;
    case (state)
      PC1: state_nxt = DC1;
      DC1: state_nxt = PC2;
      PC2: state_nxt = DC2;
      DC2: begin
        if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8)
          state_nxt = WIN;
        else if (bus.pscore <= 4'd5)
          state_nxt = PC3;
        else if (bus.dscore <= 4'd5)
          state_nxt = DC3;
        else
          state_nxt = WIN;
      end
      PC3:     state_nxt = dealer_draws(bus.dscore, card_value(bus.pcard3)) ? DC3 : WIN;
      DC3:     state_nxt = WIN;
      WIN:     state_nxt = WIN;
      default: state_nxt = PC1;  // unused code 7 recovers to a fresh game
    endcase
  end

  // State register with registered load enables and WIN flag. Reset restarts the game at PC1.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state   <= PC1;
      loads_q <= 6'b100000;
      win_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      loads_q <= load_decode(state_nxt);
      win_q   <= (state_nxt == WIN);
    end
  end

  assign bus.load_pcard1 = loads_q[5];
  assign bus.load_pcard2 = loads_q[4];
  assign bus.load_pcard3 = loads_q[3];
  assign bus.load_dcard1 = loads_q[2];
  assign bus.load_dcard2 = loads_q[1];
  assign bus.load_dcard3 = loads_q[0];

  // Lights follow the live scores while in WIN. A tie lights both.
  assign bus.player_win_light = win_q && (bus.pscore >= bus.dscore);
  assign bus.dealer_win_light = win_q && (bus.dscore >= bus.pscore);

endmodule

// File: tb/tb_state_machine.sv
// Self-checking bench for the baccarat controller: vector table, third-card sweep, async reset cases.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none.
module tb_state_machine;

  logic slow_clock;
  logic resetb;

  state_machine_if bus ();

  state_machine dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus.master)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic       rst;    // reset before applying this row
    logic [3:0] ps;
    logic [3:0] ds;
    logic [3:0] pc3;
    int         edges;
    logic [2:0] st;
    logic [5:0] ld;     // {p1,p2,p3,d1,d2,d3}
    logic       pl;
    logic       dl;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [5:0] ld;
    logic       pl;
    logic       dl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [5:0] dut_loads();
    return {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
            bus.load_dcard1, bus.load_dcard2, bus.load_dcard3};
  endfunction

  // Pop the oldest expectation and compare the DUT against it
  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".state"}, int'(dut.state), int'(e.st));
    check({e.name, ".loads"}, int'(dut_loads()), int'(e.ld));
    check({e.name, ".plight"}, int'(bus.player_win_light), int'(e.pl));
    check({e.name, ".dlight"}, int'(bus.dealer_win_light), int'(e.dl));
  endtask

  task automatic expect_now(input string name, input logic [2:0] st, input logic [5:0] ld,
                            input logic pl, input logic dl);
    exp_t e;
    e.name = name; e.st = st; e.ld = ld; e.pl = pl; e.dl = dl;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge slow_clock);
    resetb = 1'b0;
    #2;
    resetb = 1'b1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge slow_clock);
    #1;
  endtask

  task automatic add(input logic rst, input logic [3:0] ps, input logic [3:0] ds,
                     input logic [3:0] pc3, input int edges, input logic [2:0] st,
                     input logic [5:0] ld, input logic pl, input logic dl);
    vec_t v;
    v.rst = rst; v.ps = ps; v.ds = ds; v.pc3 = pc3; v.edges = edges;
    v.st = st; v.ld = ld; v.pl = pl; v.dl = dl;
    vecs.push_back(v);
  endtask

  // Independent reference for the banker rule: draw when v is inside [lo,hi] for that score
  function automatic logic ref_draw(input int ds, input int pc);
    int v;
    v = (pc >= 1 && pc <= 9) ? pc : 0;
    case (ds)
      0, 1, 2: return 1'b1;
      3:       return !(v == 8);
      4:       return (v inside {[2:7]});
      5:       return (v inside {[4:7]});
      6:       return (v inside {[6:7]});
      default: return 1'b0;
    endcase
  endfunction

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: got running, expected finished");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

  initial begin
    resetb     = 1'b1;
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd0;

    // Opening sequence, step by step
    add(1, 2, 2, 0, 0, 3'd0, 6'b100000, 0, 0);
    add(0, 2, 2, 0, 1, 3'd1, 6'b000100, 0, 0);
    add(0, 2, 2, 0, 1, 3'd2, 6'b010000, 0, 0);
    add(0, 2, 2, 0, 1, 3'd3, 6'b000010, 0, 0);
    // Player natural, then hold
    add(1, 8, 5, 0, 4, 3'd6, 6'b000000, 1, 0);
    add(0, 8, 5, 0, 1, 3'd6, 6'b000000, 1, 0);
    // Dealer natural, then hold
    add(1, 5, 8, 0, 4, 3'd6, 6'b000000, 0, 1);
    add(0, 5, 8, 0, 1, 3'd6, 6'b000000, 0, 1);
    // Player draws, dealer stands
    add(1, 3, 7, 0, 4, 3'd4, 6'b001000, 0, 0);
    add(0, 6, 7, 0, 2, 3'd6, 6'b000000, 0, 1);
    // Both draw
    add(1, 4, 6, 0, 4, 3'd4, 6'b001000, 0, 0);
    add(0, 0, 6, 6, 1, 3'd5, 6'b000001, 0, 0);
    add(0, 0, 4, 6, 1, 3'd6, 6'b000000, 0, 1);
    // Player stands on 7, dealer 5 draws
    add(1, 7, 5, 0, 4, 3'd5, 6'b000001, 0, 0);
    add(0, 7, 6, 0, 1, 3'd6, 6'b000000, 1, 0);
    // Two-card stand tie, natural tie, stand 6 vs 7
    add(1, 6, 6, 0, 4, 3'd6, 6'b000000, 1, 1);
    add(1, 9, 9, 0, 4, 3'd6, 6'b000000, 1, 1);
    add(1, 6, 7, 0, 4, 3'd6, 6'b000000, 0, 1);
    // Tie after both draw
    add(1, 5, 6, 6, 4, 3'd4, 6'b001000, 0, 0);
    add(0, 5, 6, 6, 1, 3'd5, 6'b000001, 0, 0);
    add(0, 1, 1, 6, 1, 3'd6, 6'b000000, 1, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      bus.pscore = vecs[i].ps;
      bus.dscore = vecs[i].ds;
      bus.pcard3 = vecs[i].pc3;
      expect_now($sformatf("vec%0d", i), vecs[i].st, vecs[i].ld, vecs[i].pl, vecs[i].dl);
      if (vecs[i].edges == 0) #1;
      else step(vecs[i].edges);
      compare_head();
    end

    // In WIN the lights follow score changes with no clock edge
    bus.pscore = 4'd9;
    #1;
    check("live_light.player", int'(bus.player_win_light), 1);
    check("live_light.dealer", int'(bus.dealer_win_light), 0);
    bus.dscore = 4'd9;
    #1;
    check("live_tie.player", int'(bus.player_win_light), 1);
    check("live_tie.dealer", int'(bus.dealer_win_light), 1);

    // Reset asserted in WIN, between edges, takes effect at once
    @(negedge slow_clock);
    resetb = 1'b0;
    #1;
    expect_now("reset_in_win", 3'd0, 6'b100000, 0, 0);
    compare_head();
    #1 resetb = 1'b1;

    // Reset asserted mid-game (PC2) aborts to PC1 without an edge
    bus.pscore = 4'd2; bus.dscore = 4'd2;
    step(2);
    check("midgame.pre_state", int'(dut.state), 2);
    #2 resetb = 1'b0;
    #1;
    expect_now("reset_midgame", 3'd0, 6'b100000, 0, 0);
    compare_head();
    // Held reset ignores edges
    step(1);
    check("held_reset.state", int'(dut.state), 0);
    #2 resetb = 1'b1;

    // Banker third-card sweep: reach PC3, then apply each dscore/pcard3 pair for one edge
    for (int ds = 0; ds < 10; ds++) begin
      for (int pc = 0; pc < 16; pc++) begin
        logic d;
        do_reset();
        bus.pscore = 4'd3; bus.dscore = 4'd0; bus.pcard3 = 4'd0;
        step(4);
        bus.dscore = 4'(ds);
        bus.pcard3 = 4'(pc);
        d = ref_draw(ds, pc);
        step(1);
        check($sformatf("rule.ds%0d.pc%0d", ds, pc), int'(dut.state), d ? 5 : 6);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
